ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a PS/2 device.
// The PS/2 lines are driven open-drain: an *_oe output of 1 pulls the line low.
// A frame is inhibit (clock held low), request-to-send (data low, clock
// released), ten device-clocked bits (8 data LSB first, odd parity, stop),
// then the device ACK bit.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles ps2 clock is held low before the start bit
//   TIMEOUT_CYCLES  max clk cycles from clock release to end of ACK/idle
//   FILT_LEN        ps2_clk_in filter depth (filtered build only)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   tx_data      command byte, sampled when tx_start is accepted
//   tx_start     one-cycle request, ignored unless idle
//   ps2_clk_in   PS2_CLK pin level (asynchronous)
//   ps2_data_in  PS2_DATA pin level (asynchronous)
//   ps2_clk_oe   1 = pull PS2_CLK low
//   ps2_data_oe  1 = pull PS2_DATA low
//   busy         transaction in progress
//   done         one-cycle pulse at the end of a transaction
//   err_code     0 ok, 1 NACK, 2 timeout; held until the next accepted start
//
// Build option:
//   PS2_TX_FILTER_EN  when defined, the synchronised ps2 clock passes a
//                     FILT_LEN-deep agreement filter before edge detection.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2600,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILT_LEN       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  state_t           state;
  logic [9:0]       frame;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_lvl;
  logic       clk_prev;
  logic       clk_fall;
  logic       data_s;
  logic       timed_out;

  // Idle bus level is high, so synchronisers reset to 1 to avoid a
  // spurious falling edge right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  assign data_s = data_sync[1];

`ifdef PS2_TX_FILTER_EN
  logic [FILT_LEN-1:0] filt_sr;
  logic                filt_lvl;

  // The filtered level only moves once every sample in the window agrees.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_sr  <= '1;
      filt_lvl <= 1'b1;
    end else begin
      filt_sr <= (filt_sr << 1) | FILT_LEN'(clk_sync[1]);
      if (&filt_sr) begin
        filt_lvl <= 1'b1;
      end else if (~|filt_sr) begin
        filt_lvl <= 1'b0;
      end
    end
  end

  assign clk_lvl = filt_lvl;
`else
  assign clk_lvl = clk_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_prev <= 1'b1;
    end else begin
      clk_prev <= clk_lvl;
    end
  end

  assign clk_fall  = clk_prev & ~clk_lvl;
  assign timed_out = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_code    <= '0;
    end else begin
      done <= 1'b0;
      // Timeout takes priority over any edge seen in the same cycle.
      if ((state == SHIFT || state == ACK || state == WAIT_IDLE) && timed_out) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        err_code    <= 2'd2;
        busy        <= 1'b0;
        done        <= 1'b1;
        state       <= DONE;
      end else begin
        unique case (state)
          IDLE: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            if (tx_start) begin
              frame      <= {1'b1, ~^tx_data, tx_data};
              err_code   <= '0;
              busy       <= 1'b1;
              cnt        <= '0;
              bit_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              state      <= INHIBIT;
            end
          end

          INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          // Start bit is already low; releasing the clock hands timing
          // over to the device.
          REQ: begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= SHIFT;
          end

          SHIFT: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              ps2_data_oe <= ~frame[0];
              frame       <= {1'b0, frame[9:1]};
              bit_cnt     <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) begin
                state <= ACK;
              end
            end
          end

          ACK: begin
            cnt         <= cnt + 1'b1;
            ps2_data_oe <= 1'b0;
            if (clk_fall) begin
              if (data_s) begin
                err_code <= 2'd1;
              end
              state <= WAIT_IDLE;
            end
          end

          WAIT_IDLE: begin
            cnt <= cnt + 1'b1;
            if (clk_lvl && data_s) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned INH  = 100;
  localparam int unsigned TMO  = 20000;
  localparam int unsigned HALF = 250;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILT_LEN(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .err_code(err_code)
  );

  typedef struct {
    logic [1:0] err;
    bit         has_frame;
    logic [9:0] bits;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] cap_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] last_err = 2'd0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, req);
    end
  endtask

  // Reference frame as the device sees it: data LSB first, then a parity
  // bit making the total count of ones odd, then the stop bit.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  exp_t mon_e;

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("err_code", err_code, mon_e.err);
        chk("oe_at_done", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("busy_at_done", busy, 0);
        if (mon_e.has_frame) begin
          if (cap_q.size() == 0) chk("frame_captured", 0, 1);
          else chk("frame_bits", cap_q.pop_front(), mon_e.bits);
        end
      end
    end
  end

  // mode: 0 ACK, 1 NACK, 2 silent device, 3 reset after 4th edge,
  //       4 ACK with a tx_start pulse during the frame
  task automatic run_tx(input logic [7:0] d, input int mode);
    int         hi;
    int         hi_nodata;
    int         n;
    bit         ok;
    logic [9:0] cap;
    exp_t       e;

    chk("err_code_held", err_code, last_err);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    chk("busy_after_start", busy, 1);

    hi = 0;
    hi_nodata = 0;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (ps2_clk_oe) begin
        hi++;
        if (!ps2_data_oe) hi_nodata++;
      end else if (!ps2_data_in) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("clk_inhibit_cycles", hi, INH + 1);
    chk("data_oe_rise_cycle", hi_nodata + 1, INH + 1);
    if (!ok) begin
      chk("rts_seen", 0, 1);
      return;
    end

    if (mode != 3) begin
      e.err       = (mode == 1) ? 2'd1 : (mode == 2) ? 2'd2 : 2'd0;
      e.has_frame = (mode != 2);
      e.bits      = ref_frame(d);
      exp_q.push_back(e);
    end

    if (mode == 2) begin
      n = 0;
      while (n < int'(TMO) + 2000) begin
        @(negedge clk);
        n++;
        if (done) break;
      end
      chk("timeout_cycles", n, TMO);
      last_err = 2'd2;
    end else begin
      repeat (50) @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        if (mode == 3 && i == 4) begin
          reset = 1'b0;
          @(negedge clk);
          chk("reset_oe_release", {ps2_clk_oe, ps2_data_oe}, 0);
          chk("reset_busy", busy, 0);
          chk("reset_err_code", err_code, 0);
          reset = 1'b1;
          dev_clk = 1'b1;
          last_err = 2'd0;
          repeat (HALF) @(negedge clk);
          return;
        end
        dev_clk = 1'b1;
        if (i <= 10) cap[i-1] = ps2_data_in;
        if (i == 10) cap_q.push_back(cap);
        if (mode == 4 && i == 4) begin
          tx_data  = ~d;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          repeat (HALF - 1) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
        if (i == 10 && mode != 1) dev_data = 1'b0;
      end
      dev_data = 1'b1;
      last_err = (mode == 1) ? 2'd1 : 2'd0;
    end

    for (int t = 0; t < 200; t++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("busy_release", busy, 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, err_code}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    run_tx(8'hED, 0);
    run_tx(8'h01, 0);
    run_tx(8'($urandom), 1);
    run_tx(8'($urandom), 2);
    run_tx(8'($urandom), 3);
    run_tx(8'hFF, 0);
    run_tx(8'($urandom), 4);
    for (int k = 0; k < 3; k++) run_tx(8'($urandom), int'($urandom_range(0, 1)));

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("captures_drained", cap_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
